alu_pipe: RTL and testbench

Handshaked, registered successor to the combinational 6502-style ALU, generalised to WIDTH bits.
- Adds decimal-mode (BCD) ADC/SBC, executed nibble-serially over multiple cycles.
- Adds CMP/INC/DEC and output back-pressure.
- Sits between the decode/sequencer and the accumulator/status registers.
- Binary ops complete in one cycle; BCD ops take WIDTH/4+1 cycles.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/bcd_digit_adder.sv | 44 ++++
 rtl/alu_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, status bit positions,
// FSM state encoding and the BCD digit width.
package alu_pkg;

    localparam int unsigned DigitW = 4;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpAdc  = 4'd1;
    localparam logic [3:0] OpSbc  = 4'd2;
    localparam logic [3:0] OpAnd  = 4'd3;
    localparam logic [3:0] OpEor  = 4'd4;
    localparam logic [3:0] OpOra  = 4'd5;
    localparam logic [3:0] OpBit  = 4'd6;
    localparam logic [3:0] OpAsl  = 4'd7;
    localparam logic [3:0] OpLsr  = 4'd8;
    localparam logic [3:0] OpRol  = 4'd9;
    localparam logic [3:0] OpRor  = 4'd10;
    localparam logic [3:0] OpPass = 4'd11;
    localparam logic [3:0] OpCmp  = 4'd12;
    localparam logic [3:0] OpInc  = 4'd13;
    localparam logic [3:0] OpDec  = 4'd14;
    localparam logic [3:0] OpRsvd = 4'd15;

    localparam int unsigned FlagC = 7;
    localparam int unsigned FlagZ = 6;
    localparam int unsigned FlagI = 5;
    localparam int unsigned FlagD = 4;
    localparam int unsigned FlagB = 3;
    localparam int unsigned FlagV = 1;
    localparam int unsigned FlagN = 0;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/bcd_digit_adder.sv
// One BCD nibble add/subtract with decimal adjust. For subtraction cin/cout
// carry the 6502 sense of "no borrow".
module bcd_digit_adder
    import alu_pkg::*;
(
    input  logic [DigitW-1:0] a,
    input  logic [DigitW-1:0] b,
    input  logic              cin,
    input  logic              sub,
    output logic [DigitW-1:0] sum,
    output logic              cout
);

    logic [DigitW:0] raw;
    logic [DigitW:0] adj;

    always_comb begin
        raw  = '0;
        adj  = '0;
        cout = 1'b0;
        if (!sub) begin
            raw = {1'b0, a} + {1'b0, b} + {{DigitW{1'b0}}, cin};
            if (raw > 5'd9) begin
                adj  = raw + 5'd6;
                cout = 1'b1;
            end else begin
                adj  = raw;
                cout = 1'b0;
            end
        end else begin
            // Top bit of the 5-bit difference is the digit borrow.
            raw = {1'b0, a} - {1'b0, b} - {{DigitW{1'b0}}, ~cin};
            if (raw[DigitW]) begin
                adj  = raw - 5'd6;
                cout = 1'b0;
            end else begin
                adj  = raw;
                cout = 1'b1;
            end
        end
        sum = adj[DigitW-1:0];
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked 6502-style ALU: binary ops finish in one cycle, decimal ADC/SBC
// walk the operands one BCD digit per cycle, LSB first.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] accumulator,
    input  logic [WIDTH-1:0] operand_2,
    input  logic [7:0]       status,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       status_out,
    output logic             busy
);

    localparam int unsigned NumDigits = WIDTH / DigitW;
    localparam int unsigned KW        = $clog2(NumDigits);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [7:0]       st_q, st_d;
    logic             carry_q, carry_d;
    logic             bin_v_q, bin_v_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [7:0]       status_out_q, status_out_d;

    logic [WIDTH-1:0] arith_b;
    logic             arith_cin;
    logic [WIDTH:0]   arith_sum;
    logic             arith_v;
    logic [WIDTH-1:0] bin_res;
    logic [WIDTH-1:0] flag_src;
    logic [7:0]       bin_st;
    logic             dec_start;

    logic [DigitW-1:0] digit_a, digit_m, digit_sum;
    logic              digit_cout;

    // Shared adder for ADD/ADC/SBC/CMP; SBC and CMP add the complement of M.
    always_comb begin
        arith_b   = operand_2;
        arith_cin = 1'b0;
        case (op)
            OpAdc: arith_cin = status[FlagC];
            OpSbc: begin
                arith_b   = ~operand_2;
                arith_cin = status[FlagC];
            end
            OpCmp: begin
                arith_b   = ~operand_2;
                arith_cin = 1'b1;
            end
            default: ;
        endcase
        arith_sum = {1'b0, accumulator} + {1'b0, arith_b} + {{WIDTH{1'b0}}, arith_cin};
        arith_v   = (accumulator[WIDTH-1] == arith_b[WIDTH-1]) &&
                    (arith_sum[WIDTH-1] != accumulator[WIDTH-1]);
    end

    always_comb begin
        bin_res = '0;
        bin_st  = status;
        case (op)
            OpAdd, OpAdc, OpSbc: begin
                bin_res       = arith_sum[WIDTH-1:0];
                bin_st[FlagC] = arith_sum[WIDTH];
                bin_st[FlagV] = arith_v;
            end
            OpCmp: begin
                bin_res       = accumulator;
                bin_st[FlagC] = arith_sum[WIDTH];
            end
            OpAnd:  bin_res = accumulator & operand_2;
            OpEor:  bin_res = accumulator ^ operand_2;
            OpOra:  bin_res = accumulator | operand_2;
            OpBit: begin
                bin_res       = accumulator;
                bin_st[FlagV] = operand_2[WIDTH-2];
            end
            OpAsl: begin
                bin_res       = {operand_2[WIDTH-2:0], 1'b0};
                bin_st[FlagC] = operand_2[WIDTH-1];
            end
            OpRol: begin
                bin_res       = {operand_2[WIDTH-2:0], status[FlagC]};
                bin_st[FlagC] = operand_2[WIDTH-1];
            end
            OpLsr: begin
                bin_res       = {1'b0, operand_2[WIDTH-1:1]};
                bin_st[FlagC] = operand_2[0];
            end
            OpRor: begin
                bin_res       = {status[FlagC], operand_2[WIDTH-1:1]};
                bin_st[FlagC] = operand_2[0];
            end
            OpPass: bin_res = operand_2;
            OpInc:  bin_res = operand_2 + WIDTH'(1);
            OpDec:  bin_res = operand_2 - WIDTH'(1);
            default: ;
        endcase

        // CMP reports Z/N of the difference while returning A unchanged.
        flag_src = (op == OpCmp) ? arith_sum[WIDTH-1:0] : bin_res;
        case (op)
            OpBit: begin
                bin_st[FlagZ] = ((accumulator & operand_2) == '0);
                bin_st[FlagN] = operand_2[WIDTH-1];
            end
            OpRsvd: ;
            default: begin
                bin_st[FlagZ] = (flag_src == '0);
                bin_st[FlagN] = flag_src[WIDTH-1];
            end
        endcase
    end

    assign dec_start = ((op == OpAdc) || (op == OpSbc)) && status[FlagD];

    assign digit_a = a_q[DigitW*k_q +: DigitW];
    assign digit_m = m_q[DigitW*k_q +: DigitW];

    bcd_digit_adder u_digit (
        .a    (digit_a),
        .b    (digit_m),
        .cin  (carry_q),
        .sub  (op_q == OpSbc),
        .sum  (digit_sum),
        .cout (digit_cout)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        op_d         = op_q;
        a_d          = a_q;
        m_d          = m_q;
        st_d         = st_q;
        carry_d      = carry_q;
        bin_v_d      = bin_v_q;
        result_d     = result_q;
        status_out_d = status_out_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = accumulator;
                    m_d     = operand_2;
                    st_d    = status;
                    bin_v_d = bin_st[FlagV];
                    if (dec_start) begin
                        state_d = StCalc;
                        k_d     = '0;
                        carry_d = status[FlagC];
                    end else begin
                        state_d      = StDone;
                        result_d     = bin_res;
                        status_out_d = bin_st;
                    end
                end
            end
            StCalc: begin
                result_d[DigitW*k_q +: DigitW] = digit_sum;
                carry_d = digit_cout;
                k_d     = k_q + KW'(1);
                if (k_q == KW'(NumDigits - 1)) begin
                    state_d             = StDone;
                    status_out_d        = st_q;
                    status_out_d[FlagC] = digit_cout;
                    status_out_d[FlagZ] = (result_d == '0);
                    status_out_d[FlagN] = result_d[WIDTH-1];
                    status_out_d[FlagV] = bin_v_q;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            k_q          <= '0;
            op_q         <= '0;
            a_q          <= '0;
            m_q          <= '0;
            st_q         <= '0;
            carry_q      <= 1'b0;
            bin_v_q      <= 1'b0;
            result_q     <= '0;
            status_out_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            op_q         <= op_d;
            a_q          <= a_d;
            m_q          <= m_d;
            st_q         <= st_d;
            carry_q      <= carry_d;
            bin_v_q      <= bin_v_d;
            result_q     <= result_d;
            status_out_q <= status_out_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign result     = result_q;
    assign status_out = status_out_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized ops checked
// against an arithmetic reference model; a 16-bit instance covers wide ADD.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]  op;
    logic [7:0]  accumulator, operand_2, status, result, status_out;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [3:0]  op16;
    logic [15:0] accumulator16, operand_216, result16;
    logic [7:0]  status16, status_out16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .accumulator (accumulator),
        .operand_2   (operand_2),
        .status      (status),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .status_out  (status_out),
        .busy        (busy)
    );

    alu_pipe #(.WIDTH(16)) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid16),
        .in_ready    (in_ready16),
        .op          (op16),
        .accumulator (accumulator16),
        .operand_2   (operand_216),
        .status      (status16),
        .out_valid   (out_valid16),
        .out_ready   (out_ready16),
        .result      (result16),
        .status_out  (status_out16),
        .busy        (busy16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn8(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    // Reference model for the 8-bit instance; returns result, flags and latency.
    function automatic void model(input logic [3:0] o, input int a, input int m,
                                  input logic [7:0] st, output int res,
                                  output logic [7:0] so, output int lat);
        int c, sb, s, sv, carry, da, dm, fv;
        logic [7:0] f8;
        c   = int'(st[7]);
        so  = st;
        lat = 1;
        res = 0;
        fv  = 0;
        case (o)
            4'd0, 4'd1, 4'd2: begin
                sb    = (o == 4'd2) ? 255 - m : m;
                s     = a + sb + ((o == 4'd0) ? 0 : c);
                res   = s % 256;
                so[7] = (s > 255);
                sv    = sgn8(a) + sgn8(sb) + ((o == 4'd0) ? 0 : c);
                so[1] = (sv > 127) || (sv < -128);
                if (o != 4'd0 && st[4]) begin
                    lat   = 3;
                    carry = c;
                    res   = 0;
                    for (int i = 0; i < 2; i++) begin
                        da = (a >> (4 * i)) & 15;
                        dm = (m >> (4 * i)) & 15;
                        if (o == 4'd1) begin
                            s = da + dm + carry;
                            if (s > 9) begin s = s + 6; carry = 1; end
                            else carry = 0;
                        end else begin
                            s = da - dm - (1 - carry);
                            if (s < 0) begin s = s - 6; carry = 0; end
                            else carry = 1;
                        end
                        res = res + ((s & 15) << (4 * i));
                    end
                    so[7] = (carry != 0);
                end
                fv = res;
            end
            4'd3:  begin res = a & m; fv = res; end
            4'd4:  begin res = a ^ m; fv = res; end
            4'd5:  begin res = a | m; fv = res; end
            4'd6: begin
                res   = a;
                so[6] = ((a & m) == 0);
                so[0] = (m >= 128);
                so[1] = ((m / 64) % 2) == 1;
            end
            4'd7:  begin res = (m * 2) % 256;         so[7] = (m >= 128);    fv = res; end
            4'd8:  begin res = m / 2;                  so[7] = (m % 2 == 1);  fv = res; end
            4'd9:  begin res = (m * 2) % 256 + c;     so[7] = (m >= 128);    fv = res; end
            4'd10: begin res = m / 2 + 128 * c;        so[7] = (m % 2 == 1);  fv = res; end
            4'd11: begin res = m; fv = res; end
            4'd12: begin res = a; so[7] = (a >= m); fv = (a - m + 256) % 256; end
            4'd13: begin res = (m + 1) % 256; fv = res; end
            4'd14: begin res = (m + 255) % 256; fv = res; end
            default: res = 0;
        endcase
        if (o != 4'd6 && o != 4'd15) begin
            f8    = 8'(fv);
            so[6] = (f8 == 8'h00);
            so[0] = f8[7];
        end
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] m,
                          input logic [7:0] st, input int hold);
        int exp_res, exp_lat, lat;
        logic [7:0] exp_st;
        model(o, int'(a), int'(m), st, exp_res, exp_st, exp_lat);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        in_valid    = 1'b1;
        op          = o;
        accumulator = a;
        operand_2   = m;
        status      = st;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        op          = 4'($urandom_range(0, 15));
        accumulator = 8'($urandom);
        operand_2   = 8'($urandom);
        status      = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            check("busy_in_calc", busy, 1);
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid", out_valid, 1);
        check("latency", lat, exp_lat);
        check("result", result, exp_res);
        check("status_out", status_out, exp_st);
        check("busy_done", busy, 1);
        check("in_ready_done", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, exp_res);
            check("hold_status", status_out, exp_st);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; op = '0;
        accumulator = '0; operand_2 = '0; status = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = '0;
        accumulator16 = '0; operand_216 = '0; status16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_status_out", status_out, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'd1,  8'h50, 8'h50, 8'h00, 0);
        run_op(4'd1,  8'h58, 8'h46, 8'h90, 0);
        run_op(4'd2,  8'h40, 8'h13, 8'h90, 0);
        run_op(4'd12, 8'h10, 8'h20, 8'h00, 0);
        run_op(4'd10, 8'h00, 8'h01, 8'h80, 0);
        run_op(4'd7,  8'h00, 8'h80, 8'h00, 0);
        run_op(4'd6,  8'h0F, 8'hC0, 8'h24, 5);
        run_op(4'd14, 8'h00, 8'h00, 8'h00, 0);
        run_op(4'd2,  8'h00, 8'h01, 8'h10, 2);

        // Reset while a decimal op is in flight must drop it silently.
        @(negedge clk);
        in_valid = 1'b1; op = 4'd1; accumulator = 8'h12; operand_2 = 8'h34; status = 8'h10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("calc_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_status", status_out, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_valid", out_valid, 0);
        end

        for (int i = 0; i < 200; i++) begin
            run_op(4'($urandom_range(0, 14)), 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 2)));
        end

        @(negedge clk);
        in_valid16 = 1'b1; op16 = 4'd0;
        accumulator16 = 16'hFFFF; operand_216 = 16'h0001; status16 = 8'h00;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        check("w16_valid", out_valid16, 1);
        check("w16_result", result16, 16'h0000);
        check("w16_status", status_out16, 8'hC0);
        @(negedge clk);
        out_ready16 = 1'b1;
        @(posedge clk);
        #1;
        out_ready16 = 1'b0;
        check("w16_in_ready", in_ready16, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
